uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Transmit-side UART for the ALU datapath: buffers result bytes in a small FIFO and serializes them onto tx_o as 8N1 frames (start bit, 8 data bits LSB first, 1 stop bit).
- It is the counterpart of the design's UART receiver and sits between the ALU response logic and the board TX pin.
- It runs entirely in the PLL-derived system clock domain.

Parameters:
- CLK_HZ, 28500000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bits per second.
- FIFO_DEPTH, 16, number of byte entries. Must be a power of 2 and at least 2.
- Derived constant DIV = (CLK_HZ + BAUD_RATE/2) / BAUD_RATE (nearest integer). The default gives 247. Elaboration fails if DIV < 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- data_i  input  8  byte to transmit.
- valid_i  input  1  data_i is valid this cycle.
- ready_o  output  1  FIFO can accept a byte (FIFO not full).
- level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.
- busy_o  output  1  a frame is in progress or the FIFO is non-empty.
- tx_o  output  1  serial line. Idle level is high.

Behaviour:
- Reset (async assert, sync release): tx_o=1, ready_o=1, level_o=0, busy_o=0, FSM=IDLE, baud counter=0, bit index=0, FIFO pointers=0.
- Reset asserted mid-frame:
  - tx_o returns high immediately.
  - All queued bytes are discarded.
  - No partial frame resumes after release.
- Push: on a clk edge with valid_i && ready_o, data_i is written at the write pointer and level increments. valid_i while ready_o=0 is ignored; the byte is dropped and state is unchanged.
- ready_o = (level < FIFO_DEPTH). It is derived from registered state only, with no combinational path from valid_i.
- Pop: happens only when the FSM loads a byte. Push and pop on the same edge leave level unchanged. A push into an empty FIFO is never popped on the same edge; there is no bypass.
- Pointers wrap modulo FIFO_DEPTH. level_o distinguishes full (FIFO_DEPTH) from empty (0).
- FSM states:
  - IDLE: tx_o=1. If level>0 at an edge: pop the head into the shift register, set tx_o=0, clear the baud counter, go to START.
  - START: hold tx_o=0 for exactly DIV cycles. Then drive shift[0], set bit index 0, go to DATA.
  - DATA: each bit is held DIV cycles, LSB first. After bit 7's DIV cycles, set tx_o=1 and go to STOP.
  - STOP: hold tx_o=1 for DIV cycles. At the end, if level>0, pop and go directly to START with tx_o=0 (back-to-back, no idle gap). Otherwise go to IDLE.
- Timing:
  - A frame lasts exactly 10*DIV cycles.
  - tx_o falls on the edge after the accepting edge when the FSM is IDLE. A byte accepted at edge N produces tx_o=0 after edge N+1.
  - All outputs are registered except ready_o and busy_o, which decode registers.
- busy_o = (FSM != IDLE) || (level != 0).
- The baud counter counts 0..DIV-1 and is reset on every state or bit transition. There is no fractional-rate accumulation.

Test Plan:
- Reset release with CLK_HZ=1000000, BAUD_RATE=250000 (DIV=4), no input -> tx_o=1, ready_o=1, level_o=0, busy_o=0 for 100 cycles.
- Push 0xA5 once (DIV=4) -> tx_o low 1 cycle after accept, then 40-cycle waveform 0,1,0,1,0,0,1,0,1,1 (4 cycles per bit), busy_o drops the cycle after the stop bit ends.
- Push 0x00,0xFF,0x3C back-to-back with valid_i held high (DIV=4) -> three contiguous frames totalling 120 cycles, no idle between stop and start, decoded bytes match in order.
- Fill with FIFO_DEPTH=4 (DIV=4):
  - Hold valid_i high with incrementing data 0x10.. -> ready_o=0 once level_o=4, and bytes offered while ready_o=0 never appear on the line.
  - Continue until 8 bytes total -> wrap-around exercised, received sequence has no gaps or duplicates.
- Assert rst at cycle 15 of a frame (DIV=4) with 3 bytes queued -> tx_o=1 immediately, level_o=0, no further frames after release.
- Default parameters (DIV=247), push 0x41 -> each bit period measures exactly 247 cycles and the frame exactly 2470 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of an 8N1 UART transmitter (LSB first).
// Ports: clk, rst (async high), data_i/valid_i/ready_o push side, level_o, busy_o, tx_o line.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 28500000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        busy_o,
  output logic                        tx_o
);

  localparam int DIV = (CLK_HZ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);

  localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 4) begin : g_div_chk
    $error("uart_tx_fifo: baud divider below 4");
  end

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   level;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tx;

  logic has_data;
  logic tick;
  logic push;
  logic pop;

  assign has_data = (level != '0);
  assign tick     = (cnt == LAST);
  assign ready_o  = (level < FULL);
  assign push     = valid_i && ready_o;

  // Pops only when the FSM loads a frame; level is the registered value,
  // so a byte pushed into an empty FIFO waits one edge (no bypass).
  assign pop = has_data && ((state == IDLE) || (state == STOP && tick));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      level <= level + (AW + 1)'(push) - (AW + 1)'(pop);

      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (pop) begin
            shift <= mem[rptr];
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            cnt     <= '0;
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            cnt <= '0;
            // Next byte starts right away: no idle gap between frames.
            if (pop) begin
              shift <= mem[rptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign level_o = level;
  assign tx_o    = tx;
  assign busy_o  = (state != IDLE) || has_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo.
// Instance a: DIV=4, depth 4 (model + decoder); instance b: default rates.
module tb_uart_tx_fifo;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;
  localparam int DIVB  = 247;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic [7:0] data_b = 8'h00;
  logic       valid_a = 1'b0;
  logic       valid_b = 1'b0;
  logic       ready_a;
  logic       ready_b;
  logic       busy_a;
  logic       busy_b;
  logic       tx_a;
  logic       tx_b;
  logic [2:0] level_a;
  logic [4:0] level_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_HZ(1000000),
    .BAUD_RATE(250000),
    .FIFO_DEPTH(DEPTH)
  ) u_a (
    .clk(clk),
    .rst(rst),
    .data_i(data_a),
    .valid_i(valid_a),
    .ready_o(ready_a),
    .level_o(level_a),
    .busy_o(busy_a),
    .tx_o(tx_a)
  );

  uart_tx_fifo u_b (
    .clk(clk),
    .rst(rst),
    .data_i(data_b),
    .valid_i(valid_b),
    .ready_o(ready_b),
    .level_o(level_b),
    .busy_o(busy_b),
    .tx_o(tx_b)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Behavioural model of instance a: FIFO contents plus frame timer.
  byte unsigned mq[$];
  byte unsigned sb[$];
  bit           m_busy = 1'b0;
  int           m_pos = 0;
  byte unsigned m_byte = 8'h00;
  bit           chk_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      sb.delete();
      m_busy = 1'b0;
      m_pos  = 0;
    end else begin : upd
      bit acc;
      acc = valid_a && (mq.size() < DEPTH);
      if (mq.size() > 0 && (!m_busy || m_pos == FRAME - 1)) begin
        m_byte = mq.pop_front();
        m_busy = 1'b1;
        m_pos  = 0;
      end else if (m_busy) begin
        if (m_pos == FRAME - 1) m_busy = 1'b0;
        else m_pos++;
      end
      if (acc) begin
        mq.push_back(data_a);
        sb.push_back(data_a);
      end
    end
  end

  function automatic logic exp_tx();
    int b;
    if (!m_busy) return 1'b1;
    b = m_pos / DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_tx", tx_a, exp_tx());
      check("m_level", level_a, mq.size());
      check("m_ready", ready_a, mq.size() < DEPTH);
      check("m_busy", busy_a, m_busy || mq.size() != 0);
    end
  end

  // Line decoder for instance a; compares each frame with the scoreboard.
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  int         frames = 0;

  always @(negedge clk) begin
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx_a === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt > DIV && rx_cnt < 9 * DIV && rx_cnt % DIV == DIV / 2) begin
        rx_byte[rx_cnt/DIV-1] = tx_a;
      end else if (rx_cnt == 9 * DIV + DIV / 2) begin
        rx_act = 1'b0;
        frames++;
        check("rx_stop", tx_a, 1'b1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got frame %02h, expected none", rx_byte);
        end else begin
          check("rx_byte", rx_byte, sb.pop_front());
        end
      end
    end
  end

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] wave;
  } vec_t;

  vec_t vecs[5];

  task automatic send_one(input logic [7:0] b, input logic [9:0] w,
                          input int idx);
    int mism;
    step();
    valid_a = 1'b1;
    data_a  = b;
    step();
    valid_a = 1'b0;
    check($sformatf("v%0d_tx_pre", idx), tx_a, 1'b1);
    check($sformatf("v%0d_busy_pre", idx), busy_a, 1'b1);
    for (int i = 0; i < 10; i++) begin
      mism = 0;
      for (int c = 0; c < DIV; c++) begin
        step();
        if (tx_a !== w[i]) mism++;
      end
      check($sformatf("v%0d_bit%0d_bad", idx, i), mism, 0);
    end
    step();
    check($sformatf("v%0d_busy_post", idx), busy_a, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         bad_tx;
    int         bad_rdy;
    int         bad_lvl;
    int         bad_busy;
    int         mism;
    int         n;
    int         f0;
    logic [0:119] arr;

    vecs[0] = '{data: 8'hA5, wave: 10'b1101001010};
    vecs[1] = '{data: 8'h00, wave: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, wave: 10'b1111111110};
    vecs[3] = '{data: 8'h3C, wave: 10'b1001111000};
    vecs[4] = '{data: 8'h41, wave: 10'b1010000010};

    #1 rst = 1'b1;
    chk_en = 1'b1;
    step();
    step();
    check("rst_tx", tx_a, 1'b1);
    check("rst_ready", ready_a, 1'b1);
    check("rst_level", level_a, 3'd0);
    check("rst_busy", busy_a, 1'b0);
    rst = 1'b0;

    bad_tx = 0; bad_rdy = 0; bad_lvl = 0; bad_busy = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (tx_a !== 1'b1) bad_tx++;
      if (ready_a !== 1'b1) bad_rdy++;
      if (level_a !== 3'd0) bad_lvl++;
      if (busy_a !== 1'b0) bad_busy++;
    end
    check("idle_tx_bad", bad_tx, 0);
    check("idle_ready_bad", bad_rdy, 0);
    check("idle_level_bad", bad_lvl, 0);
    check("idle_busy_bad", bad_busy, 0);

    for (int v = 0; v < 5; v++) begin
      send_one(vecs[v].data, vecs[v].wave, v);
    end

    // Three bytes back-to-back: 120 contiguous line samples.
    step();
    valid_a = 1'b1;
    data_a  = vecs[1].data;
    step();
    data_a = vecs[2].data;
    step();
    arr[0] = tx_a;
    data_a = vecs[3].data;
    step();
    valid_a = 1'b0;
    arr[1] = tx_a;
    for (int k = 2; k < 120; k++) begin
      step();
      arr[k] = tx_a;
    end
    for (int f = 0; f < 3; f++) begin
      mism = 0;
      for (int k = 0; k < FRAME; k++) begin
        if (arr[f*FRAME+k] !== vecs[f+1].wave[k/DIV]) mism++;
      end
      check($sformatf("b2b_frame%0d_bad", f), mism, 0);
    end
    step();
    check("b2b_tx_end", tx_a, 1'b1);
    check("b2b_busy_end", busy_a, 1'b0);

    // Fill: depth 4, valid held; 0xEE offered only while full.
    f0 = frames;
    n = 0;
    step();
    for (int cyc = 0; cyc < 600 && n < 8; cyc++) begin
      if (mq.size() < DEPTH) begin
        data_a = 8'(8'h10 + n);
        n++;
      end else begin
        data_a = 8'hEE;
      end
      valid_a = 1'b1;
      step();
      if (cyc == 4) begin
        check("fill_level4", level_a, 3'd4);
        check("fill_ready0", ready_a, 1'b0);
      end
    end
    valid_a = 1'b0;
    check("fill_count", n, 8);
    for (int k = 0; k < 1000 && busy_a; k++) step();
    check("fill_drain_busy", busy_a, 1'b0);
    check("fill_frames", frames - f0, 8);

    // Reset during the 16th cycle of a frame with three bytes queued.
    step();
    valid_a = 1'b1;
    data_a  = 8'h51;
    step();
    data_a = 8'h52;
    step();
    data_a = 8'h53;
    step();
    data_a = 8'h54;
    step();
    valid_a = 1'b0;
    for (int k = 0; k < 13; k++) step();
    check("rstmid_level_pre", level_a, 3'd3);
    check("rstmid_tx_pre", tx_a, 1'b0);
    f0 = frames;
    rst = 1'b1;
    #1;
    check("rstmid_tx", tx_a, 1'b1);
    check("rstmid_level", level_a, 3'd0);
    check("rstmid_busy", busy_a, 1'b0);
    step();
    step();
    rst = 1'b0;
    bad_tx = 0;
    bad_busy = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (tx_a !== 1'b1) bad_tx++;
      if (busy_a !== 1'b0) bad_busy++;
    end
    check("rstmid_after_tx_bad", bad_tx, 0);
    check("rstmid_after_busy_bad", bad_busy, 0);
    check("rstmid_frames", frames - f0, 0);

    // Default rate: 0x41, each bit exactly 247 cycles.
    step();
    valid_b = 1'b1;
    data_b  = 8'h41;
    step();
    valid_b = 1'b0;
    check("def_tx_pre", tx_b, 1'b1);
    check("def_level", level_b, 5'd1);
    check("def_ready", ready_b, 1'b1);
    for (int i = 0; i < 10; i++) begin
      mism = 0;
      for (int c = 0; c < DIVB; c++) begin
        step();
        if (tx_b !== vecs[4].wave[i]) mism++;
      end
      check($sformatf("def_bit%0d_bad", i), mism, 0);
    end
    step();
    check("def_busy_post", busy_b, 1'b0);
    check("def_tx_post", tx_b, 1'b1);

    check("sb_drained", sb.size(), 0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
